window_burst_streamer: RTL and testbench

Downstream consumer of the threshold cutter's trigger. On each `read_start` pulse it issues one AXI4 INCR read burst from the window RAM at `araddr_start`, buffers one beat at a time, and streams the beats out as a framed byte stream: header, data bytes LSB-first, then XOR checksum. The byte stream goes to the UART transmitter. The block sits between the cutter's `AXI_reader_read_start`/`AXI_reader_axi_araddr_start` outputs and the AXI RAM read port.

---
 rtl/window_stream_pkg.sv | 20 ++
 rtl/beat_serializer.sv | 64 ++++++
 rtl/window_burst_streamer.sv | 144 ++++++++++++++
 tb/tb_window_burst_streamer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/window_stream_pkg.sv
// Shared types and AXI constants for the window RAM burst streamer.
package window_stream_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_HDR,
    S_RDATA,
    S_SEND,
    S_CSUM
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  function automatic logic [2:0] ARSIZE(input int unsigned bytes);
    return 3'($clog2(bytes));
  endfunction

endpackage

// File: rtl/beat_serializer.sv
// Holds one AXI beat and hands it out a byte at a time, LSB first, keeping
// a running XOR of every byte accepted downstream.
module beat_serializer #(
  parameter int unsigned DATA_BYTE_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_clear,
  input  logic                         i_load,
  input  logic [DATA_BYTE_WIDTH*8-1:0] i_data,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [7:0]                   o_byte,
  output logic                         o_last,
  output logic [7:0]                   o_csum
);

  localparam int unsigned IDX_W = (DATA_BYTE_WIDTH > 1) ? $clog2(DATA_BYTE_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BYTE_WIDTH - 1);

  logic [DATA_BYTE_WIDTH*8-1:0] r_buf;
  logic [IDX_W-1:0]             r_idx;
  logic                         r_valid;
  logic [7:0]                   r_csum;
  logic [DATA_BYTE_WIDTH*8-1:0] w_shifted;
  logic                         w_accept;

  assign w_shifted = r_buf >> {r_idx, 3'b000};
  assign o_byte    = w_shifted[7:0];
  assign o_last    = (r_idx == LAST_IDX);
  assign o_valid   = r_valid;
  assign o_csum    = r_csum;
  assign w_accept  = r_valid && i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf   <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_buf   <= i_data;
      r_idx   <= '0;
      r_valid <= 1'b1;
    end else if (w_accept) begin
      if (o_last) begin
        r_idx   <= '0;
        r_valid <= 1'b0;
      end else begin
        r_idx   <= r_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_csum <= '0;
    end else if (i_clear) begin
      r_csum <= '0;
    end else if (w_accept) begin
      r_csum <= r_csum ^ o_byte;
    end
  end

endmodule

// File: rtl/window_burst_streamer.sv
// Reads one AXI4 INCR burst from the window RAM per start pulse and streams it
// out as a framed byte stream: header, data bytes LSB-first, XOR checksum.
module window_burst_streamer
  import window_stream_pkg::*;
#(
  parameter int unsigned DATA_BYTE_WIDTH = 32,
  parameter int unsigned BURST_LEN       = 16,
  parameter logic [3:0]  AXI_ID          = 4'd0,
  parameter logic [7:0]  HEADER_BYTE     = 8'hA5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         read_start,
  input  logic [31:0]                  araddr_start,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic [3:0]                   axi_arid,
  output logic [31:0]                  axi_araddr,
  output logic [7:0]                   axi_arlen,
  output logic [2:0]                   axi_arsize,
  output logic [1:0]                   axi_arburst,
  output logic                         axi_arvalid,
  input  logic                         axi_arready,
  input  logic [3:0]                   axi_rid,
  input  logic [DATA_BYTE_WIDTH*8-1:0] axi_rdata,
  input  logic [1:0]                   axi_rresp,
  input  logic                         axi_rlast,
  input  logic                         axi_rvalid,
  output logic                         axi_rready,
  output logic [7:0]                   tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready
);

  localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

  state_t      r_state, w_next;
  logic [31:0] r_araddr;
  logic [7:0]  r_beat;
  logic        r_err;
  logic        r_done;

  logic        w_start;
  logic        w_r_hs;
  logic        w_final;
  logic        w_beat_bad;
  logic        w_ser_valid;
  logic        w_ser_ready;
  logic        w_ser_last;
  logic [7:0]  w_ser_byte;
  logic [7:0]  w_csum;
  logic        w_beat_sent;

  // A start coinciding with the done pulse is dropped even though the FSM is idle.
  assign w_start     = read_start && (r_state == S_IDLE) && !r_done;
  assign w_r_hs      = (r_state == S_RDATA) && axi_rvalid;
  assign w_final     = (r_beat == LAST_BEAT);
  assign w_beat_bad  = (axi_rresp != AXI_RESP_OKAY) || (axi_rid != AXI_ID) ||
                       (axi_rlast != w_final);
  assign w_ser_ready = (r_state == S_SEND) && tx_ready;
  assign w_beat_sent = w_ser_valid && w_ser_ready && w_ser_last;

  assign axi_arid    = AXI_ID;
  assign axi_araddr  = r_araddr;
  assign axi_arlen   = LAST_BEAT;
  assign axi_arsize  = ARSIZE(DATA_BYTE_WIDTH);
  assign axi_arburst = AXI_BURST_INCR;
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign err         = r_err;

  beat_serializer #(
    .DATA_BYTE_WIDTH(DATA_BYTE_WIDTH)
  ) u_ser (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_start),
    .i_load  (w_r_hs),
    .i_data  (axi_rdata),
    .o_valid (w_ser_valid),
    .i_ready (w_ser_ready),
    .o_byte  (w_ser_byte),
    .o_last  (w_ser_last),
    .o_csum  (w_csum)
  );

  always_comb begin
    w_next      = r_state;
    axi_arvalid = 1'b0;
    axi_rready  = 1'b0;
    tx_valid    = 1'b0;
    tx_data     = '0;
    unique case (r_state)
      S_IDLE:  if (w_start) w_next = S_ADDR;
      S_ADDR: begin
        axi_arvalid = 1'b1;
        if (axi_arready) w_next = S_HDR;
      end
      S_HDR: begin
        tx_valid = 1'b1;
        tx_data  = HEADER_BYTE;
        if (tx_ready) w_next = S_RDATA;
      end
      S_RDATA: begin
        axi_rready = 1'b1;
        if (axi_rvalid) w_next = S_SEND;
      end
      S_SEND: begin
        tx_valid = w_ser_valid;
        tx_data  = w_ser_byte;
        if (w_beat_sent) w_next = w_final ? S_CSUM : S_RDATA;
      end
      S_CSUM: begin
        tx_valid = 1'b1;
        tx_data  = w_csum;
        if (tx_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_araddr <= '0;
      r_beat   <= '0;
      r_err    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == S_CSUM) && tx_ready;
      if (w_start) begin
        r_araddr <= araddr_start;
        r_beat   <= '0;
        r_err    <= 1'b0;
      end else begin
        if (w_r_hs && w_beat_bad) r_err <= 1'b1;
        if (w_beat_sent && !w_final) r_beat <= r_beat + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_window_burst_streamer.sv
// Scoreboard bench: stimulus pushes expected frames, a monitor pops on every tx handshake.
module tb_window_burst_streamer;

  localparam int unsigned DBW   = 32;
  localparam int unsigned BL    = 16;
  localparam int unsigned NDATA = BL * DBW;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             read_start;
  logic [31:0]      araddr_start;
  logic             busy, done, err;
  logic [3:0]       axi_arid;
  logic [31:0]      axi_araddr;
  logic [7:0]       axi_arlen;
  logic [2:0]       axi_arsize;
  logic [1:0]       axi_arburst;
  logic             axi_arvalid;
  logic             axi_arready;
  logic [3:0]       axi_rid;
  logic [DBW*8-1:0] axi_rdata;
  logic [1:0]       axi_rresp;
  logic             axi_rlast;
  logic             axi_rvalid;
  logic             axi_rready;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready = 1'b1;

  always #5 clk = ~clk;

  window_burst_streamer #(
    .DATA_BYTE_WIDTH(DBW),
    .BURST_LEN      (BL),
    .AXI_ID         (4'd0),
    .HEADER_BYTE    (8'hA5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .read_start(read_start), .araddr_start(araddr_start),
    .busy(busy), .done(done), .err(err),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready), .axi_rid(axi_rid), .axi_rdata(axi_rdata),
    .axi_rresp(axi_rresp), .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid),
    .axi_rready(axi_rready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0]  exp_q[$];
  logic [31:0] exp_ar_q[$];
  logic        exp_err_q[$];

  int          ar_delay = 0;
  bit          r_gaps = 1'b0;
  bit          tx_rand = 1'b0;
  int          bad_resp_beat = -1;
  int          rlast_beat = BL - 1;
  logic [31:0] poke_addr = 32'hFFFF_FFFF;

  int ar_hs_cnt = 0;
  int bytes_seen = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // RAM content: byte k holds k mod 256, optionally with one byte flipped by 5A.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [7:0] b;
    b = a[7:0];
    if (a == poke_addr) b = b ^ 8'h5A;
    return b;
  endfunction

  task automatic push_frame(input logic [31:0] base, input logic [7:0] csum, input logic e);
    exp_q.push_back(8'hA5);
    for (int k = 0; k < int'(NDATA); k++) exp_q.push_back(mem_byte(base + 32'(k)));
    exp_q.push_back(csum);
    exp_ar_q.push_back(base);
    exp_err_q.push_back(e);
  endtask

  // AXI RAM read slave
  initial begin : slave
    int ss, wcnt, beat;
    bit ar_hs, r_hs, arv;
    logic [31:0] sbase;
    ss = 0; wcnt = 0; beat = 0; sbase = '0;
    axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rdata = '0;
    axi_rresp = 2'b00; axi_rlast = 1'b0; axi_rid = 4'd0;
    forever begin
      @(negedge clk);
      ar_hs = axi_arvalid && axi_arready;
      r_hs  = axi_rvalid && axi_rready;
      arv   = axi_arvalid;
      if (ar_hs) sbase = axi_araddr;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        ss = 0; wcnt = 0; beat = 0;
        axi_arready = 1'b0; axi_rvalid = 1'b0;
        continue;
      end
      if (ss == 0) begin
        if (ar_hs) begin
          axi_arready = 1'b0; ss = 1; beat = 0; wcnt = 0;
        end else if (arv) begin
          if (wcnt >= ar_delay) axi_arready = 1'b1;
          else wcnt++;
        end
      end
      if (ss == 1) begin
        if (r_hs) begin
          axi_rvalid = 1'b0;
          beat++;
          if (beat == int'(BL)) ss = 0;
        end
        if (ss == 1 && !axi_rvalid && !(r_gaps && $urandom_range(0, 1) == 1)) begin
          for (int j = 0; j < int'(DBW); j++)
            axi_rdata[j*8 +: 8] = mem_byte(sbase + 32'(beat * int'(DBW) + j));
          axi_rresp  = (beat == bad_resp_beat) ? 2'b10 : 2'b00;
          axi_rlast  = (beat == rlast_beat);
          axi_rid    = 4'd0;
          axi_rvalid = 1'b1;
        end
      end
    end
  end

  initial begin : sink
    forever begin
      @(posedge clk);
      #1;
      tx_ready = tx_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin : monitor
    int cyc, last_hs;
    bit pv_tx, pv_ar, pdone;
    logic [7:0] pdata;
    logic [31:0] paddr, a;
    cyc = 0; last_hs = -10; pv_tx = 0; pv_ar = 0; pdone = 0; pdata = '0; paddr = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        pv_tx = 0; pv_ar = 0; pdone = 0;
        continue;
      end
      if (pv_tx) begin
        chk("tx_hold_valid", tx_valid, 1);
        chk("tx_hold_data", tx_data, pdata);
      end
      if (pv_ar) begin
        chk("ar_hold_valid", axi_arvalid, 1);
        chk("ar_hold_addr", axi_araddr, paddr);
      end
      if (axi_arvalid && axi_arready) begin
        ar_hs_cnt++;
        if (exp_ar_q.size() == 0) chk("ar_unexpected", 1, 0);
        else begin
          a = exp_ar_q.pop_front();
          chk("araddr", axi_araddr, a);
          chk("arlen", axi_arlen, 8'd15);
          chk("arsize", axi_arsize, 3'd5);
          chk("arburst", axi_arburst, 2'b01);
          chk("arid", axi_arid, 4'd0);
        end
      end
      if (tx_valid && tx_ready) begin
        bytes_seen++;
        last_hs = cyc;
        if (exp_q.size() == 0) chk("tx_extra_byte", 1, 0);
        else chk("tx_byte", tx_data, exp_q.pop_front());
      end
      if (done) begin
        done_cnt++;
        chk("done_after_csum", cyc - last_hs, 1);
        chk("busy_at_done", busy, 0);
        chk("done_one_cycle", pdone, 0);
        chk("frame_bytes_left", exp_q.size(), 0);
        if (exp_err_q.size() == 0) chk("done_unexpected", 1, 0);
        else chk("err_at_done", err, exp_err_q.pop_front());
      end
      pv_tx = tx_valid && !tx_ready;
      pdata = tx_data;
      pv_ar = axi_arvalid && !axi_arready;
      paddr = axi_araddr;
      pdone = done;
    end
  end

  task automatic check_reset_values();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_arvalid", axi_arvalid, 0);
    chk("rst_araddr", axi_araddr, 0);
    chk("rst_arlen", axi_arlen, 8'd15);
    chk("rst_arsize", axi_arsize, 3'd5);
    chk("rst_arburst", axi_arburst, 2'b01);
    chk("rst_arid", axi_arid, 4'd0);
    chk("rst_rready", axi_rready, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
  endtask

  task automatic start_frame(input logic [31:0] base, input logic [7:0] csum, input logic e);
    push_frame(base, csum, e);
    @(posedge clk);
    #1;
    araddr_start = base;
    read_start = 1'b1;
    @(posedge clk);
    #1;
    read_start = 1'b0;
    chk("arvalid_after_start", axi_arvalid, 1);
    chk("busy_after_start", busy, 1);
    chk("err_cleared_on_start", err, 0);
  endtask

  task automatic wait_done();
    int n0;
    n0 = done_cnt;
    for (int i = 0; i < 20000 && done_cnt == n0; i++) @(negedge clk);
    chk("frame_timeout", done_cnt != n0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [31:0] base, input logic [7:0] csum, input logic e);
    start_frame(base, csum, e);
    wait_done();
  endtask

  initial begin : main
    int n_ar, b0;
    read_start = 1'b0;
    araddr_start = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_frame(32'h0000_0000, 8'h00, 1'b0);

    ar_delay = 5; r_gaps = 1'b1;
    run_frame(32'h0000_0000, 8'h00, 1'b0);

    ar_delay = 0; r_gaps = 1'b0; tx_rand = 1'b1; poke_addr = 32'h0000_0105;
    run_frame(32'h0000_0100, 8'h5A, 1'b0);

    tx_rand = 1'b0; poke_addr = 32'hFFFF_FFFF; bad_resp_beat = 3; rlast_beat = 14;
    run_frame(32'h0000_0000, 8'h00, 1'b1);

    bad_resp_beat = -1; rlast_beat = BL - 1;
    run_frame(32'h0000_0040, 8'h00, 1'b0);

    // starts during SEND and coincident with done must both be dropped
    n_ar = ar_hs_cnt;
    b0 = bytes_seen;
    start_frame(32'h0000_0200, 8'h00, 1'b0);
    for (int i = 0; i < 5000 && bytes_seen < b0 + 100; i++) @(negedge clk);
    chk("reach_send", bytes_seen >= b0 + 100, 1);
    araddr_start = 32'hDEAD_0000;
    read_start = 1'b1;
    @(posedge clk);
    #1;
    read_start = 1'b0;
    for (int i = 0; i < 20000 && !done; i++) @(negedge clk);
    chk("done_seen", done, 1);
    read_start = 1'b1;
    @(posedge clk);
    #1;
    read_start = 1'b0;
    repeat (10) @(negedge clk);
    chk("ar_handshakes", ar_hs_cnt - n_ar, 1);
    chk("busy_after_ignored", busy, 0);

    // async reset mid-SEND abandons the frame
    b0 = bytes_seen;
    start_frame(32'h0000_0000, 8'h00, 1'b0);
    for (int i = 0; i < 5000 && bytes_seen < b0 + 50; i++) @(negedge clk);
    chk("reach_send_rst", bytes_seen >= b0 + 50, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    exp_ar_q.delete();
    exp_err_q.delete();
    @(negedge clk);
    check_reset_values();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    run_frame(32'h0000_0080, 8'h00, 1'b0);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
